// File: rtl/mem_arb_pkg.sv
// Shared types and default widths for the memory-bus arbiters.
package mem_arb_pkg;

  localparam int DEFAULT_ADDR_W = 21;
  localparam int DEFAULT_DATA_W = 64;
  localparam int MAX_CORES      = 8;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ISSUE     = 2'd1,
    WAIT_RESP = 2'd2
  } arb_state_t;

  typedef logic [$clog2(MAX_CORES)-1:0] core_id_t;

endpackage

// File: rtl/rr_priority_picker.sv
// Combinational round-robin picker: first valid requester after rr_ptr, wrapping.
module rr_priority_picker #(
  parameter int NUM_REQ = 2,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] valid,
  input  logic [IDX_W-1:0]   rr_ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDX_W-1:0]   grant_idx
);

  logic             found;
  logic [IDX_W-1:0] idx;

  // Scan rr_ptr+1 .. rr_ptr+NUM_REQ so the last winner has lowest priority.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    idx       = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = IDX_W'((int'(rr_ptr) + k) % NUM_REQ);
      if (!found && valid[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        grant_idx  = idx;
      end
    end
  end

endmodule

// File: rtl/dram_core_arbiter.sv
// Round-robin arbiter sharing one DRAM bus between per-core ports, one transaction in flight.
// Optional response watchdog enabled by defining DRAM_ARB_TIMEOUT_EN.
module dram_core_arbiter
  import mem_arb_pkg::*;
#(
  parameter int NUM_CORES      = 2,
  parameter int ADDR_W         = DEFAULT_ADDR_W,
  parameter int DATA_W         = DEFAULT_DATA_W,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_CORES-1:0]          core_req_valid,
  input  logic [NUM_CORES-1:0]          core_req_write,
  input  logic [NUM_CORES*ADDR_W-1:0]   core_req_addr,
  input  logic [NUM_CORES*DATA_W-1:0]   core_req_wdata,
  output logic [NUM_CORES-1:0]          core_req_ready,
  output logic [NUM_CORES-1:0]          core_resp_valid,
  output logic [DATA_W-1:0]             core_resp_rdata,
  output logic                          core_resp_error,
  output logic                          dram_req_valid,
  input  logic                          dram_req_ready,
  output logic                          dram_req_write,
  output logic [ADDR_W-1:0]             dram_req_addr,
  output logic [DATA_W-1:0]             dram_req_wdata,
  output logic [$clog2(NUM_CORES)-1:0]  dram_req_core,
  input  logic                          dram_resp_valid,
  input  logic [DATA_W-1:0]             dram_resp_rdata,
  output logic                          timeout_flag
);

  localparam int                   IDX_W    = $clog2(NUM_CORES);
  localparam logic [NUM_CORES-1:0] ONE_HOT0 = NUM_CORES'(1);

  if (NUM_CORES < 2 || NUM_CORES > MAX_CORES || TIMEOUT_CYCLES < 1) begin : g_bad_cfg
    $error("dram_core_arbiter: unsupported NUM_CORES or TIMEOUT_CYCLES");
  end

  arb_state_t           state;
  logic [IDX_W-1:0]     rr_ptr;
  logic [IDX_W-1:0]     pick_idx;
  logic [NUM_CORES-1:0] pick_grant;
  logic [NUM_CORES-1:0] resp_valid_q;
  logic                 timeout_hit;

  rr_priority_picker #(
    .NUM_REQ (NUM_CORES),
    .IDX_W   (IDX_W)
  ) u_picker (
    .valid     (core_req_valid),
    .rr_ptr    (rr_ptr),
    .grant     (pick_grant),
    .grant_idx (pick_idx)
  );

  // Grant only while idle; masked during reset so no handshake is lost to it.
  assign core_req_ready  = (state == IDLE && !reset) ? pick_grant : '0;
  assign dram_req_valid  = (state == ISSUE);
  assign core_resp_valid = resp_valid_q;

`ifdef DRAM_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] wait_cnt;

  // A real response in the expiry cycle wins over the timeout.
  assign timeout_hit = (state == WAIT_RESP) && !dram_resp_valid &&
                       (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      wait_cnt        <= '0;
      core_resp_error <= 1'b0;
      timeout_flag    <= 1'b0;
    end else begin
      wait_cnt        <= (state == WAIT_RESP) ? wait_cnt + 1'b1 : '0;
      core_resp_error <= timeout_hit;
      if (timeout_hit) timeout_flag <= 1'b1;
    end
  end
`else
  assign timeout_hit     = 1'b0;
  assign core_resp_error = 1'b0;
  assign timeout_flag    = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state           <= IDLE;
      rr_ptr          <= IDX_W'(NUM_CORES - 1);
      dram_req_write  <= 1'b0;
      dram_req_addr   <= '0;
      dram_req_wdata  <= '0;
      dram_req_core   <= '0;
      resp_valid_q    <= '0;
      core_resp_rdata <= '0;
    end else begin
      resp_valid_q <= '0;
      case (state)
        IDLE: begin
          if (|pick_grant) begin
            dram_req_write <= core_req_write[pick_idx];
            dram_req_addr  <= core_req_addr[int'(pick_idx)*ADDR_W +: ADDR_W];
            dram_req_wdata <= core_req_wdata[int'(pick_idx)*DATA_W +: DATA_W];
            dram_req_core  <= pick_idx;
            rr_ptr         <= pick_idx;
            state          <= ISSUE;
          end
        end
        ISSUE: begin
          if (dram_req_ready) state <= WAIT_RESP;
        end
        WAIT_RESP: begin
          if (dram_resp_valid) begin
            core_resp_rdata <= dram_resp_rdata;
            resp_valid_q    <= ONE_HOT0 << dram_req_core;
            state           <= IDLE;
          end else if (timeout_hit) begin
            core_resp_rdata <= '0;
            resp_valid_q    <= ONE_HOT0 << dram_req_core;
            state           <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dram_core_arbiter.sv
// Self-checking bench for dram_core_arbiter: directed scenarios plus a randomized run
// compared against a transaction-level model of grants, DRAM handshakes and responses.
module tb_dram_core_arbiter;

  localparam int NC  = 3;
  localparam int AW  = 21;
  localparam int DW  = 64;
  localparam int CW  = $clog2(NC);
  localparam int TMO = 16;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic [NC-1:0]     core_req_valid, core_req_write, core_req_ready, core_resp_valid;
  logic [NC*AW-1:0]  core_req_addr;
  logic [NC*DW-1:0]  core_req_wdata;
  logic [DW-1:0]     core_resp_rdata;
  logic              core_resp_error, dram_req_valid, dram_req_ready, dram_req_write;
  logic [AW-1:0]     dram_req_addr;
  logic [DW-1:0]     dram_req_wdata, dram_resp_rdata;
  logic [CW-1:0]     dram_req_core;
  logic              dram_resp_valid, timeout_flag;

  int checks = 0;
  int failures = 0;

  // Stimulus held by the bench, one entry per core
  logic          rv[NC];
  logic          rw[NC];
  logic [AW-1:0] ra[NC];
  logic [DW-1:0] rd[NC];

  // Transaction-level reference state
  bit            m_idle, m_issue, m_wait;
  int            m_last, m_owner, cyc, resp_cycle;
  logic [NC-1:0] m_resp_exp, clr_mask;
  logic [DW-1:0] m_rdata_exp;
  logic          t_write;
  logic [AW-1:0] t_addr;
  logic [DW-1:0] t_wdata;
  int            grant_log[$];

  always #5 clk = ~clk;

  dram_core_arbiter #(
    .NUM_CORES(NC), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk(clk), .reset(reset),
    .core_req_valid(core_req_valid), .core_req_write(core_req_write),
    .core_req_addr(core_req_addr), .core_req_wdata(core_req_wdata),
    .core_req_ready(core_req_ready), .core_resp_valid(core_resp_valid),
    .core_resp_rdata(core_resp_rdata), .core_resp_error(core_resp_error),
    .dram_req_valid(dram_req_valid), .dram_req_ready(dram_req_ready),
    .dram_req_write(dram_req_write), .dram_req_addr(dram_req_addr),
    .dram_req_wdata(dram_req_wdata), .dram_req_core(dram_req_core),
    .dram_resp_valid(dram_resp_valid), .dram_resp_rdata(dram_resp_rdata),
    .timeout_flag(timeout_flag)
  );

  task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=0x%0h expected=0x%0h", tag, actual, expected);
    end
  endtask

  task automatic packInputs();
    for (int i = 0; i < NC; i++) begin
      core_req_valid[i]            = rv[i];
      core_req_write[i]            = rw[i];
      core_req_addr[i*AW +: AW]    = ra[i];
      core_req_wdata[i*DW +: DW]   = rd[i];
    end
  endtask

  task automatic setReq(input int i, input logic v, input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
    rv[i] = v; rw[i] = w; ra[i] = a; rd[i] = d;
    packInputs();
  endtask

  task automatic doReset();
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < NC; i++) begin
      rv[i] = 1'b1; rw[i] = 1'b0; ra[i] = '0; rd[i] = '0;
    end
    packInputs();
    dram_req_ready = 1'b0; dram_resp_valid = 1'b0; dram_resp_rdata = '0;
    @(negedge clk);
    #1 checkOutput("rst_ready_masked", core_req_ready, 0);
    @(negedge clk);
    checkOutput("rst_resp_valid", core_resp_valid, 0);
    checkOutput("rst_resp_rdata", core_resp_rdata, 0);
    checkOutput("rst_resp_error", core_resp_error, 0);
    checkOutput("rst_dram_valid", dram_req_valid, 0);
    checkOutput("rst_dram_write", dram_req_write, 0);
    checkOutput("rst_dram_addr", dram_req_addr, 0);
    checkOutput("rst_dram_wdata", dram_req_wdata, 0);
    checkOutput("rst_dram_core", dram_req_core, 0);
    checkOutput("rst_timeout_flag", timeout_flag, 0);
    for (int i = 0; i < NC; i++) rv[i] = 1'b0;
    packInputs();
    reset = 1'b0;
    m_idle = 1; m_issue = 0; m_wait = 0; m_last = NC - 1; m_owner = 0;
    m_resp_exp = '0; clr_mask = '0; cyc = 0; resp_cycle = -1;
    grant_log.delete();
  endtask

  task automatic applyStimulus(input int req_pct, input int ready_pct);
    for (int i = 0; i < NC; i++) begin
      if (clr_mask[i]) rv[i] = 1'b0;
      if (!rv[i] && int'($urandom_range(99)) < req_pct) begin
        rv[i] = 1'b1;
        rw[i] = 1'($urandom);
        ra[i] = AW'($urandom);
        rd[i] = {$urandom, $urandom};
      end
    end
    clr_mask = '0;
    packInputs();
    dram_req_ready  = (int'($urandom_range(99)) < ready_pct);
    dram_resp_valid = m_wait ? (cyc == resp_cycle) : ($urandom_range(7) == 0);
    dram_resp_rdata = {$urandom, $urandom};
  endtask

  task automatic runRandom(input int cycles, input int req_pct, input int ready_pct, input int lat_max);
    logic [NC-1:0] exp_ready;
    int g, idx;
    repeat (cycles) begin
      @(negedge clk);
      cyc++;
      applyStimulus(req_pct, ready_pct);
      #1;
      exp_ready = '0;
      g = -1;
      if (m_idle) begin
        for (int k = 1; k <= NC; k++) begin
          idx = (m_last + k) % NC;
          if (g < 0 && rv[idx]) g = idx;
        end
      end
      if (g >= 0) exp_ready[g] = 1'b1;
      checkOutput("rnd_ready", core_req_ready, exp_ready);
      checkOutput("rnd_dram_valid", dram_req_valid, m_issue);
      if (m_issue) begin
        checkOutput("rnd_dram_addr", dram_req_addr, t_addr);
        checkOutput("rnd_dram_wdata", dram_req_wdata, t_wdata);
        checkOutput("rnd_dram_write", dram_req_write, t_write);
        checkOutput("rnd_dram_core", dram_req_core, m_owner);
      end
      checkOutput("rnd_resp_valid", core_resp_valid, m_resp_exp);
      if (m_resp_exp != 0) checkOutput("rnd_resp_rdata", core_resp_rdata, m_rdata_exp);
      checkOutput("rnd_resp_error", core_resp_error, 0);
      checkOutput("rnd_timeout_flag", timeout_flag, 0);
      m_resp_exp = '0;
      if (g >= 0) begin
        m_idle = 0; m_issue = 1; m_owner = g; m_last = g;
        t_write = rw[g]; t_addr = ra[g]; t_wdata = rd[g];
        clr_mask[g] = 1'b1;
        grant_log.push_back(g);
      end else if (m_issue && dram_req_ready) begin
        m_issue = 0; m_wait = 1;
        resp_cycle = cyc + int'($urandom_range(lat_max, 1));
      end else if (m_wait && dram_resp_valid) begin
        m_wait = 0; m_idle = 1;
        m_resp_exp = '0;
        m_resp_exp[m_owner] = 1'b1;
        m_rdata_exp = dram_resp_rdata;
      end
    end
  endtask

  initial begin
    int cnt[NC];
    int j;
    for (int i = 0; i < NC; i++) begin
      rv[i] = 1'b0; rw[i] = 1'b0; ra[i] = '0; rd[i] = '0;
    end
    packInputs();
    dram_req_ready = 1'b0; dram_resp_valid = 1'b0; dram_resp_rdata = '0;

    $display("[TB] single read");
    doReset();
    setReq(0, 1'b1, 1'b0, 21'h1000, '0);
    #1 checkOutput("sr_ready", core_req_ready, 3'b001);
    @(negedge clk);
    setReq(0, 1'b0, 1'b0, '0, '0);
    dram_req_ready = 1'b1;
    #1 checkOutput("sr_dram_valid", dram_req_valid, 1);
    checkOutput("sr_dram_addr", dram_req_addr, 21'h1000);
    checkOutput("sr_dram_core", dram_req_core, 0);
    checkOutput("sr_dram_write", dram_req_write, 0);
    @(negedge clk);
    dram_req_ready = 1'b0;
    #1 checkOutput("sr_dram_valid_drop", dram_req_valid, 0);
    checkOutput("sr_no_early_resp", core_resp_valid, 0);
    @(negedge clk);
    checkOutput("sr_no_early_resp", core_resp_valid, 0);
    @(negedge clk);
    checkOutput("sr_no_early_resp", core_resp_valid, 0);
    dram_resp_valid = 1'b1; dram_resp_rdata = 64'hDEADBEEF;
    @(negedge clk);
    dram_resp_valid = 1'b0;
    checkOutput("sr_resp_valid", core_resp_valid, 3'b001);
    checkOutput("sr_resp_rdata", core_resp_rdata, 64'hDEADBEEF);
    @(negedge clk);
    checkOutput("sr_resp_pulse_end", core_resp_valid, 0);

    $display("[TB] simultaneous requests");
    doReset();
    setReq(0, 1'b1, 1'b0, 21'h111, '0);
    setReq(1, 1'b1, 1'b1, 21'h222, 64'h55);
    #1 checkOutput("sim_first_grant", core_req_ready, 3'b001);
    @(negedge clk);
    setReq(0, 1'b0, 1'b0, '0, '0);
    dram_req_ready = 1'b1;
    #1 checkOutput("sim_core_tag0", dram_req_core, 0);
    checkOutput("sim_ready_busy", core_req_ready, 0);
    @(negedge clk);
    dram_req_ready = 1'b0;
    dram_resp_valid = 1'b1; dram_resp_rdata = 64'h1234;
    @(negedge clk);
    dram_resp_valid = 1'b0;
    #1 checkOutput("sim_resp0", core_resp_valid, 3'b001);
    checkOutput("sim_second_grant", core_req_ready, 3'b010);
    @(negedge clk);
    setReq(1, 1'b0, 1'b0, '0, '0);
    #1 checkOutput("sim_core_tag1", dram_req_core, 1);
    checkOutput("sim_write1", dram_req_write, 1);
    checkOutput("sim_wdata1", dram_req_wdata, 64'h55);

    $display("[TB] backpressure and reset mid-transaction");
    doReset();
    setReq(0, 1'b1, 1'b1, 21'h1ABCD, 64'hCAFE_F00D_0000_0001);
    #1 checkOutput("bp_ready", core_req_ready, 3'b001);
    @(negedge clk);
    setReq(0, 1'b0, 1'b0, '0, '0);
    dram_req_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #1 checkOutput("bp_valid_hold", dram_req_valid, 1);
      checkOutput("bp_addr_hold", dram_req_addr, 21'h1ABCD);
      checkOutput("bp_wdata_hold", dram_req_wdata, 64'hCAFE_F00D_0000_0001);
      checkOutput("bp_write_hold", dram_req_write, 1);
      @(negedge clk);
    end
    dram_req_ready = 1'b1;
    #1 checkOutput("bp_valid_6th", dram_req_valid, 1);
    @(negedge clk);
    dram_req_ready = 1'b0;
    #1 checkOutput("bp_accepted", dram_req_valid, 0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    dram_resp_valid = 1'b1; dram_resp_rdata = 64'hBAD;
    setReq(0, 1'b1, 1'b0, 21'h10, '0);
    setReq(1, 1'b1, 1'b0, 21'h20, '0);
    #1 checkOutput("rmo_core0_priority", core_req_ready, 3'b001);
    checkOutput("rmo_no_resp", core_resp_valid, 0);
    @(negedge clk);
    dram_resp_valid = 1'b0;
    setReq(0, 1'b0, 1'b0, '0, '0);
    setReq(1, 1'b0, 1'b0, '0, '0);
    #1 checkOutput("rmo_no_resp_late", core_resp_valid, 0);
    checkOutput("rmo_issue_core0", dram_req_core, 0);
    checkOutput("rmo_issue_valid", dram_req_valid, 1);

`ifdef DRAM_ARB_TIMEOUT_EN
    $display("[TB] response timeout");
    doReset();
    setReq(0, 1'b1, 1'b0, 21'h20, '0);
    @(negedge clk);
    setReq(0, 1'b0, 1'b0, '0, '0);
    dram_req_ready = 1'b1;
    @(negedge clk);
    dram_req_ready = 1'b0;
    j = 0;
    while (core_resp_valid == 0 && j < 40) begin
      @(negedge clk);
      j++;
    end
    checkOutput("tmo_latency", j, TMO);
    checkOutput("tmo_resp_valid", core_resp_valid, 3'b001);
    checkOutput("tmo_error", core_resp_error, 1);
    checkOutput("tmo_rdata", core_resp_rdata, 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checkOutput("tmo_flag_sticky", timeout_flag, 1);
      checkOutput("tmo_error_pulse", core_resp_error, 0);
    end
`endif

    $display("[TB] randomized traffic");
    doReset();
    runRandom(800, 40, 60, 4);

    $display("[TB] fairness under full load");
    doReset();
    runRandom(100, 100, 100, 1);
    checkOutput("fair_enough_grants", grant_log.size() >= 21, 1);
    for (int i = 0; i < NC; i++) cnt[i] = 0;
    for (int k = 0; k < 21 && k < grant_log.size(); k++) begin
      checkOutput("fair_order", grant_log[k], k % NC);
      cnt[grant_log[k]]++;
    end
    for (int i = 0; i < NC; i++) checkOutput("fair_share", cnt[i] <= 7, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
